coreahblite_master_stage: RTL

Per-master front end of the 4-master × 16-slave AHB-Lite matrix: the requesting side of the per-slave arbiters. It decodes each master address phase to a one-hot slave request and holds the address/control while the target slave's arbiter has not granted this master. It stalls the master with HREADY and multiplexes the data-phase response of the selected slave back to the master. Unmapped slots get a two-cycle ERROR response.

---
 rtl/coreahblite_pkg.sv | 16 +
 rtl/coreahblite_addr_decode.sv | 13 +
 rtl/coreahblite_master_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/coreahblite_pkg.sv
// coreahblite_pkg: shared constants and FSM encoding for the AHB-Lite matrix stages.
package coreahblite_pkg;
    localparam int SLOT_W     = 4;
    localparam int NUM_SLAVES = 16;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_HOLD = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;
endpackage

// File: rtl/coreahblite_addr_decode.sv
// coreahblite_addr_decode: maps an address slot to a one-hot slave select, flagging unmapped slots.
module coreahblite_addr_decode
    import coreahblite_pkg::*;
#(
    parameter logic [NUM_SLAVES-1:0] SLAVE_EN = '1
) (
    input  logic [SLOT_W-1:0]     i_slot,
    output logic [NUM_SLAVES-1:0] o_sel,
    output logic                  o_unmapped
);
    assign o_unmapped = ~SLAVE_EN[i_slot];
    assign o_sel      = o_unmapped ? '0 : NUM_SLAVES'(1) << i_slot;
endmodule

// File: rtl/coreahblite_master_stage.sv
// coreahblite_master_stage: per-master front end; decodes, holds ungranted address phases,
// stalls the master and returns the selected slave's data-phase response.
module coreahblite_master_stage
    import coreahblite_pkg::*;
#(
    parameter logic [NUM_SLAVES-1:0] SLAVE_EN = 16'hFFFF
) (
    input  logic                     i_hclk,
    input  logic                     i_hresetn,
    input  logic [31:0]              i_haddr,
    input  logic [1:0]               i_htrans,
    input  logic                     i_hwrite,
    input  logic [2:0]               i_hsize,
    input  logic                     i_hmastlock,
    output logic                     o_hready,
    output logic                     o_hresp,
    output logic [31:0]              o_hrdata,
    output logic [NUM_SLAVES-1:0]    o_saddrsel,
    output logic [31:0]              o_gatedhaddr,
    output logic [1:0]               o_gatedhtrans,
    output logic                     o_gatedhwrite,
    output logic [2:0]               o_gatedhsize,
    output logic                     o_gatedhmastlock,
    input  logic [NUM_SLAVES-1:0]    i_saddrgrant,
    input  logic [NUM_SLAVES-1:0]    i_shreadyout,
    input  logic [NUM_SLAVES-1:0]    i_shresp,
    input  logic [32*NUM_SLAVES-1:0] i_shrdata
);
    state_t              r_state;
    logic [SLOT_W-1:0]   r_data_slot;
    logic [31:0]         r_haddr;
    logic [1:0]          r_htrans;
    logic                r_hwrite;
    logic [2:0]          r_hsize;
    logic                r_lock;
    logic [SLOT_W-1:0]   w_slot;
    logic [NUM_SLAVES-1:0] w_sel;
    logic                w_unmapped;
    logic                w_ready;
    logic                w_req;
    logic                w_go;

    // While holding, the request tracks the captured address, not the live one.
    assign w_slot  = (r_state == ST_HOLD) ? r_haddr[31:28] : i_haddr[31:28];
    assign w_ready = (r_state == ST_IDLE) || (r_state == ST_ERR2) ||
                     ((r_state == ST_DATA) && i_shreadyout[r_data_slot]);
    assign w_req   = i_htrans[1] & ~w_unmapped;
    assign w_go    = i_saddrgrant[w_slot] & i_shreadyout[w_slot];

    coreahblite_addr_decode #(.SLAVE_EN(SLAVE_EN)) u_decode (
        .i_slot     (w_slot),
        .o_sel      (w_sel),
        .o_unmapped (w_unmapped)
    );

    assign o_hready = (r_state == ST_IDLE) || (r_state == ST_ERR2) ||
                      ((r_state == ST_DATA) && i_shreadyout[r_data_slot]);
    assign o_hresp  = (r_state == ST_DATA) ? i_shresp[r_data_slot] :
                      (r_state == ST_ERR1) || (r_state == ST_ERR2);
    assign o_hrdata = (r_state == ST_DATA) ? i_shrdata[{r_data_slot, 5'd0} +: 32] : '0;

    // Requests are masked during reset so a pending master cannot reach an arbiter.
    always_comb begin
        o_saddrsel       = '0;
        o_gatedhaddr     = '0;
        o_gatedhtrans    = HTRANS_IDLE;
        o_gatedhwrite    = 1'b0;
        o_gatedhsize     = '0;
        o_gatedhmastlock = 1'b0;
        if (i_hresetn) begin
            if (w_ready) begin
                o_gatedhaddr     = i_haddr;
                o_gatedhwrite    = i_hwrite;
                o_gatedhsize     = i_hsize;
                o_gatedhmastlock = i_hmastlock;
                if (w_req) begin
                    o_saddrsel    = w_sel;
                    o_gatedhtrans = i_htrans;
                end
            end else if (r_state == ST_HOLD) begin
                o_saddrsel       = w_sel;
                o_gatedhaddr     = r_haddr;
                o_gatedhtrans    = r_htrans;
                o_gatedhwrite    = r_hwrite;
                o_gatedhsize     = r_hsize;
                o_gatedhmastlock = r_lock;
            end else begin
                o_gatedhmastlock = r_lock;
            end
        end
    end

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state     <= ST_IDLE;
            r_data_slot <= '0;
            r_haddr     <= '0;
            r_htrans    <= HTRANS_IDLE;
            r_hwrite    <= 1'b0;
            r_hsize     <= '0;
            r_lock      <= 1'b0;
        end else if (w_ready) begin
            r_haddr  <= i_haddr;
            r_htrans <= i_htrans;
            r_hwrite <= i_hwrite;
            r_hsize  <= i_hsize;
            r_lock   <= i_hmastlock;
            r_state  <= !i_htrans[1] ? ST_IDLE :
                        w_unmapped   ? ST_ERR1 :
                        w_go         ? ST_DATA : ST_HOLD;
            if (w_req && w_go)
                r_data_slot <= w_slot;
        end else if (r_state == ST_HOLD) begin
            if (w_go) begin
                r_state     <= ST_DATA;
                r_data_slot <= w_slot;
            end
        end else if (r_state == ST_ERR1) begin
            r_state <= ST_ERR2;
        end
    end
endmodule
